// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding,
// NOP/bubble word and PC arithmetic helpers.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam logic [31:0] PC_INC     = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_unit_out_buf.sv
// Output buffer between the fetch FSM and the IF/ID register: holds one
// {pc, inst, valid} entry and shows zero PC plus the bubble word when empty.
module fetch_out_buf
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INST = NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        consume,
  input  logic        flush,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pc_out   <= '0;
      inst_out <= BUBBLE_INST;
      valid    <= 1'b0;
    end else if (load) begin
      pc_out   <= load_pc;
      inst_out <= load_inst;
      valid    <= 1'b1;
    end else if (consume) begin
      pc_out   <= '0;
      inst_out <= BUBBLE_INST;
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem request
// FSM, redirect/kill handling and the held {PC, instruction} output.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_ID_Write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_number_out,
  output logic [31:0] inst_out,
  output logic        fetch_valid
);

  fetch_state_t state, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  req_pc, req_pc_next;
  logic         kill, kill_next;
  logic         buf_load, buf_consume, buf_flush;

  always_comb begin
    state_next  = state;
    pc_next     = pc_reg;
    req_pc_next = req_pc;
    kill_next   = kill;
    buf_load    = 1'b0;
    buf_consume = 1'b0;
    buf_flush   = 1'b0;
    if (branch_taken) begin
      pc_next   = word_align(branch_target);
      buf_flush = 1'b1;
      case (state)
        IDLE, HOLD: state_next = REQ;
        REQ: begin
          // Request to the stale address is already in flight; drop its reply.
          if (imem_ready) begin
            state_next = WAIT;
            kill_next  = 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_next = REQ;
            kill_next  = 1'b0;
          end else begin
            kill_next = 1'b1;
          end
        end
      endcase
    end else begin
      case (state)
        IDLE: state_next = REQ;
        REQ: begin
          if (imem_ready) begin
            state_next  = WAIT;
            req_pc_next = pc_reg;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill_next  = 1'b0;
              state_next = REQ;
            end else begin
              buf_load   = 1'b1;
              pc_next    = req_pc + PC_INC;
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          if (IF_ID_Write) begin
            buf_consume = 1'b1;
            state_next  = REQ;
          end
        end
      endcase
    end
  end

  // Request outputs are registered from next-state so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc_reg    <= RESET_PC;
      req_pc    <= '0;
      kill      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_next;
      pc_reg    <= pc_next;
      req_pc    <= req_pc_next;
      kill      <= kill_next;
      imem_req  <= (state_next == REQ);
      imem_addr <= word_align(pc_next);
    end
  end

  fetch_out_buf #(
    .BUBBLE_INST(BUBBLE_INST)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .consume   (buf_consume),
    .flush     (buf_flush),
    .load_pc   (req_pc),
    .load_inst (imem_rdata),
    .pc_out    (PC_number_out),
    .inst_out  (inst_out),
    .valid     (fetch_valid)
  );

endmodule
